// File: rtl/arith_op_scheduler.sv
// rtl/arith_op_scheduler.sv - round-robin scheduler sharing one add/subtract datapath between two requesters
// Optional per-requester operation counters: define ARITH_SCHED_STATS_EN.
module arith_op_scheduler #(
  parameter int OPW  = 17,
  parameter int RESW = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic            req0_op,
  input  logic [OPW-1:0]  req0_a,
  input  logic [OPW-1:0]  req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic            req1_op,
  input  logic [OPW-1:0]  req1_a,
  input  logic [OPW-1:0]  req1_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [RESW-1:0] rsp_result,
  output logic            rsp_neg,
`ifdef ARITH_SCHED_STATS_EN
  output logic [15:0]     ops0_cnt,
  output logic [15:0]     ops1_cnt,
`endif
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic            last_grant;
  logic            op_r;
  logic            id_r;
  logic [OPW-1:0]  a_r, b_r;
  logic [RESW-1:0] ext_a, ext_b, result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Contention goes to whichever requester was not served last.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid && (!req1_valid || last_grant);
        req1_ready = req1_valid && (!req0_valid || !last_grant);
        if (req0_valid || req1_valid) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ext_a  = {{(RESW-OPW){1'b0}}, a_r};
  assign ext_b  = {{(RESW-OPW){1'b0}}, b_r};
  assign result = op_r ? (ext_a - ext_b) : (ext_a + ext_b);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      op_r       <= 1'b0;
      id_r       <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_neg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready) begin
            op_r       <= req0_op;
            a_r        <= req0_a;
            b_r        <= req0_b;
            id_r       <= 1'b0;
            last_grant <= 1'b0;
          end else if (req1_ready) begin
            op_r       <= req1_op;
            a_r        <= req1_a;
            b_r        <= req1_b;
            id_r       <= 1'b1;
            last_grant <= 1'b1;
          end
        end
        EXEC: begin
          rsp_result <= result;
          rsp_neg    <= result[RESW-1];
          rsp_id     <= id_r;
          rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef ARITH_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops0_cnt <= '0;
      ops1_cnt <= '0;
    end else begin
      if (req0_ready && ops0_cnt != 16'hFFFF) ops0_cnt <= ops0_cnt + 16'd1;
      if (req1_ready && ops1_cnt != 16'hFFFF) ops1_cnt <= ops1_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_arith_op_scheduler.sv
// tb/tb_arith_op_scheduler.sv - self-checking bench for arith_op_scheduler
module tb_arith_op_scheduler;

  localparam int OPW  = 17;
  localparam int RESW = 20;

  logic            clk;
  logic            rst_n;
  logic            req0_valid, req0_op, req1_valid, req1_op;
  logic            req0_ready, req1_ready;
  logic [OPW-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic            rsp_valid, rsp_ready, rsp_id, rsp_neg, busy;
  logic [RESW-1:0] rsp_result;
`ifdef ARITH_SCHED_STATS_EN
  logic [15:0]     ops0_cnt, ops1_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  arith_op_scheduler #(.OPW(OPW), .RESW(RESW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_neg(rsp_neg),
`ifdef ARITH_SCHED_STATS_EN
    .ops0_cnt(ops0_cnt), .ops1_cnt(ops1_cnt),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            id;
    logic            op;
    logic [OPW-1:0]  a;
    logic [OPW-1:0]  b;
    logic [RESW-1:0] exp_result;
    logic            exp_neg;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    if (v.id == 1'b0) begin
      req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
    end else begin
      req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
    end
    #1;
    check("ready0", 32'(req0_ready), 32'(v.id == 1'b0));
    check("ready1", 32'(req1_ready), 32'(v.id == 1'b1));
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '1; req0_b = '1; req1_a = '1; req1_b = '1;
    check("exec_valid", 32'(rsp_valid), 32'd0);
    check("exec_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_result", 32'(rsp_result), 32'(v.exp_result));
    check("rsp_id", 32'(rsp_id), 32'(v.id));
    check("rsp_neg", 32'(rsp_neg), 32'(v.exp_neg));
    @(negedge clk);
    check("idle_valid", 32'(rsp_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [RESW-1:0] held_result;
    int grants;
    logic exp_grant;

    vecs[0] = '{1'b0, 1'b0, 17'h00012, 17'h00034, 20'h00046, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 17'h00005, 17'h00009, 20'hFFFFC, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 17'h1FFFF, 17'h1FFFF, 20'h3FFFE, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 17'h00000, 17'h1FFFF, 20'hE0001, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 17'h1FFFF, 17'h00000, 20'h1FFFF, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 17'h00000, 17'h00000, 20'h00000, 1'b0};

    req0_valid = 0; req0_op = 0; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_op = 0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;
    do_reset();

    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_result", 32'(rsp_result), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_neg", 32'(rsp_neg), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Continuous contention after reset: grants alternate starting with 0.
    do_reset();
    @(negedge clk);
    req0_valid = 1; req0_op = 0; req0_a = 17'd1; req0_b = 17'd1;
    req1_valid = 1; req1_op = 0; req1_a = 17'd2; req1_b = 17'd2;
    grants = 0;
    exp_grant = 1'b0;
    for (int c = 0; c < 20 && grants < 4; c++) begin
      #1;
      if (req0_ready && req1_ready) check("both_ready", 32'd1, 32'd0);
      if (req0_ready || req1_ready) begin
        check("rr_grant", 32'(req1_ready), 32'(exp_grant));
        exp_grant = ~exp_grant;
        grants++;
      end
      if (rsp_valid) check("rr_result", 32'(rsp_result), rsp_id ? 32'd4 : 32'd2);
      @(negedge clk);
    end
    check("rr_grant_count", 32'(grants), 32'd4);
    req0_valid = 0; req1_valid = 0;
    repeat (3) @(negedge clk);

    // Back-pressure: hold rsp_ready low for 10 cycles with requester 1 waiting.
    rsp_ready = 1'b0;
    req0_valid = 1; req0_op = 0; req0_a = 17'd7; req0_b = 17'd8;
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 1; req1_op = 1; req1_a = 17'd3; req1_b = 17'd1;
    @(negedge clk);
    check("bp_valid", 32'(rsp_valid), 32'd1);
    held_result = rsp_result;
    check("bp_result", 32'(held_result), 32'h0000F);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== 20'h0000F || rsp_id !== 1'b0 ||
          busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
        check("bp_hold", {rsp_valid, rsp_id, busy, req0_ready, req1_ready}, 32'b10100);
      else
        n_tests++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_release_ready1", 32'(req1_ready), 32'd1);
    check("bp_keep_result", 32'(rsp_result), 32'h0000F);
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    check("bp_r1_result", 32'(rsp_result), 32'h00002);
    @(negedge clk);

    // Reset during EXEC: last grant was 1, run one op from 0 so reset value matters.
    req0_valid = 1; req0_op = 0; req0_a = 17'd9; req0_b = 17'd9;
    @(negedge clk);
    req0_valid = 0;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_result", 32'(rsp_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    req0_valid = 1; req1_valid = 1;
    #1;
    check("post_rst_ready0", 32'(req0_ready), 32'd1);
    check("post_rst_ready1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arith_op_scheduler.md
Name: arith_op_scheduler

Overview:
- Shares one 17-bit add/subtract datapath between two requesters: requester 0 is the keypad/entry path, requester 1 is the graph/evaluation path.
- Arbitrates between the requesters round-robin and latches the winner's operands.
- Sequences the single operation through the datapath and returns a registered 20-bit two's-complement result, tagged with the requester ID, over a valid/ready handshake.
- Sits between the calculator front-ends and the arithmetic unit.

Parameters:
- OPW, 17, operand width (unsigned).
- RESW, 20, result width (two's complement); must be ≥ OPW+2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  1  requester 0 operation: 0 = a+b, 1 = a−b.
- req0_a  input  OPW  requester 0 operand a.
- req0_b  input  OPW  requester 0 operand b.
- req1_valid  input  1  requester 1 has an operation pending.
- req1_ready  output  1  requester 1 operation accepted this cycle.
- req1_op  input  1  requester 1 operation: 0 = a+b, 1 = a−b.
- req1_a  input  OPW  requester 1 operand a.
- req1_b  input  OPW  requester 1 operand b.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  1  requester that issued the result.
- rsp_result  output  RESW  result.
- rsp_neg  output  1  result is negative (equals rsp_result MSB).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_neg=0, busy=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Internal operand registers cleared.
- FSM states: IDLE → EXEC → RESP → IDLE.
- IDLE:
  - reqN_ready is combinational and high only in IDLE, only for the granted requester.
  - Only one requester is granted; the other's ready stays 0.
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester ≠ last_grant is granted.
  - On handshake (valid & ready): latch op, a, b and id; update last_grant=id; go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (one cycle):
  - Operands are zero-extended to RESW, then result = a+b or a−b modulo 2^RESW.
  - Register rsp_result, rsp_neg=result[RESW−1] and rsp_id.
  - Set rsp_valid=1; go to RESP.
- RESP:
  - rsp_* hold stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: rsp_valid→0 next cycle; go to IDLE.
  - rsp_result and rsp_id keep their last values after rsp_valid drops.
- Latency: handshake in cycle N → rsp_valid high from cycle N+2.
  - Minimum issue interval is 3 cycles when rsp_ready is held high.
- Arithmetic: no overflow is possible with the default widths.
  - Sum range: 0..0x3FFFE.
  - Difference range: −0x1FFFF..+0x1FFFF.
- Requester inputs are ignored outside IDLE.
  - A requester holding valid across EXEC/RESP is served on return to IDLE, subject to the round-robin rule.
- Operand changes after the handshake have no effect.
- Reset asserted mid-operation (EXEC or RESP) aborts the operation: no response is produced and all outputs return to reset values immediately.

Optional Feature:
- ARITH_SCHED_STATS_EN defined:
  - Adds outputs ops0_cnt[15:0] and ops1_cnt[15:0].
  - Each counter increments on its requester's accepted handshake and saturates at 0xFFFF.
  - Both reset to 0 asynchronously.
- ARITH_SCHED_STATS_EN undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Requester 0 only, op=0, a=0x00012, b=0x00034, rsp_ready=1 → rsp_valid in cycle N+2 with rsp_result=0x00046, rsp_id=0, rsp_neg=0.
- Requester 1, op=1, a=5, b=9 → rsp_result=0xFFFFC, rsp_neg=1, rsp_id=1.
- Boundary values: op=0, a=b=0x1FFFF → 0x3FFFE. op=1, a=0, b=0x1FFFF → 0xE0001, rsp_neg=1.
- Both requesters valid continuously, rsp_ready=1:
  - Grants alternate 0,1,0,1 from reset.
  - Each ready pulses for exactly one cycle per grant.
  - Never both ready in the same cycle.
- rsp_ready held 0 for 10 cycles after rsp_valid → rsp_result/rsp_id stable, busy=1, both readies 0; release → IDLE next cycle.
- Assert rst_n=0 during EXEC → rsp_valid stays 0, state IDLE, busy=0 on release; requester 0 wins the next contention.
